// File: rtl/proc_pkg.sv
// Shared constants and types for the instruction fetch stage.
// Imported by the prefetch queue and the fetch unit top level.
package proc_pkg;

   localparam int ADDR_W     = 16;
   localparam int INSTR_W    = 16;
   localparam int DEPTH      = 4;
   localparam int PC_STEP    = 2;
   localparam int COUNT_W    = $clog2(DEPTH) + 1;
   localparam int OPCODE_MSB = 15;
   localparam int OPCODE_LSB = 12;

   localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_DISCARD = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc;
   } fetch_entry_t;

   function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcode_of(input logic [INSTR_W-1:0] instr);
      return instr[OPCODE_MSB:OPCODE_LSB];
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH entries of WIDTH bits, flush has priority over push/pop.
// The head reads as zero while the queue is empty.
module fetch_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   input  logic                       flush,
   output logic [$clog2(DEPTH):0]     count,
   output logic [WIDTH-1:0]           head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && ((count_q != CNT_W'(DEPTH)) || pop);
   assign do_pop  = pop && (count_q != '0);

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; count_q alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
   end

   assign count = count_q;
   assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, keeps one request in flight to instruction
// memory, queues returned instructions and hands them to decode.
module instr_fetch_unit
   import proc_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               instr_valid,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   input  logic               instr_ready
);

   fetch_state_e        state_q, state_d;
   logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0]   req_pc_q, req_pc_d;
   logic [COUNT_W-1:0]  count;
   logic                space_ok;
   logic                issue;
   logic                push;
   logic                pop;
   fetch_entry_t        push_entry;
   fetch_entry_t        head_entry;

   // Only S_IDLE issues, so nothing else is in flight and the free slot is the reservation.
   assign space_ok = (count < COUNT_W'(DEPTH));

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      issue      = 1'b0;
      push       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!redirect_valid && space_ok) begin
               issue      = 1'b1;
               state_d    = S_WAIT;
               req_pc_d   = fetch_pc_q;
               fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
            end
         end
         S_WAIT: begin
            if (imem_ack) begin
               push    = !redirect_valid;
               state_d = S_IDLE;
            end else if (redirect_valid) begin
               state_d = S_DISCARD;
            end
         end
         S_DISCARD: begin
            if (imem_ack) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (redirect_valid) fetch_pc_d = redirect_pc;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
      end
   end

   // The FSM already rests in S_IDLE during reset; gating keeps the strobe low until release.
   assign imem_req  = issue && reset;
   assign imem_addr = imem_req ? fetch_pc_q : '0;

   assign push_entry = '{instr: imem_rdata, pc: req_pc_q};
   assign pop        = instr_valid && instr_ready;

   fetch_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (reset),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .flush     (redirect_valid),
      .count     (count),
      .head      (head_entry)
   );

   assign instr_valid = (count != '0);
   assign instr       = instr_valid ? head_entry.instr : '0;
   assign instr_pc    = instr_valid ? head_entry.pc    : '0;

endmodule
